sixty_four_bit_brentkung_sub_pipe: RTL and testbench

- Pipelined 64-bit subtractor: diff = A - B - bin, built on a Brent-Kung parallel-prefix carry tree.
- It is the inverse operation of the team's sixty_four_bit_brentkung adder.
- Two register stages with valid/ready handshakes on both sides, so it can sit in a streaming datapath next to the adder.
- The borrow chain is cut between the up-sweep and the down-sweep of the prefix tree.

---
 rtl/bk_sub_pkg.sv | 18 +
 rtl/bk_prefix_cell.sv | 14 +
 rtl/sixty_four_bit_brentkung_sub_pipe.sv | 113 +++++++++++
 tb/tb_sixty_four_bit_brentkung_sub_pipe.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bk_sub_pkg.sv
// bk_sub_pkg: shared types, defaults and Brent-Kung prefix index helpers for the pipelined subtractor
package bk_sub_pkg;
  localparam int WIDTH_DEFAULT = 64;
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
  typedef struct packed {
    logic v1;
    logic v2;
  } stg_vld_t;
  function automatic bit up_node(int l, int i);
    return ((i + 1) % (2 << l)) == 0;
  endfunction
  function automatic bit down_node(int l, int i);
    return (((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l));
  endfunction
endpackage

// File: rtl/bk_prefix_cell.sv
// bk_prefix_cell: Brent-Kung black cell, or gray cell (group propagate passed through) when GRAY=1
module bk_prefix_cell #(
  parameter bit GRAY = 1'b0
) (
  input  logic i_gh,
  input  logic i_ph,
  input  logic i_gl,
  input  logic i_pl,
  output logic o_g,
  output logic o_p
);
  assign o_g = i_gh | (i_ph & i_gl);
  assign o_p = i_ph & (GRAY | i_pl);
endmodule

// File: rtl/sixty_four_bit_brentkung_sub_pipe.sv
// sixty_four_bit_brentkung_sub_pipe: 2-stage Brent-Kung A-B-bin with valid/ready; BK_SUB_OVERFLOW_EN adds signed ovf output
module sixty_four_bit_brentkung_sub_pipe
  import bk_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef BK_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  stg_vld_t r_v;
  logic w_adv1, w_adv2;
  gp_t [WIDTH-1:0] w_gp0, w_up, r_gp1, w_fin;
  logic [WIDTH-1:0] r_p1, w_g, w_p_unused, w_diff, r_diff;
  logic r_c0, r_bout;
  assign w_adv2   = !r_v.v2 | out_ready;
  assign w_adv1   = !r_v.v1 | w_adv2;
  assign in_ready = w_adv1;
  // c0 = ~bin is folded into bit 0's generate so every group G is directly a carry
  for (genvar i = 0; i < WIDTH; i++) begin : g_in
    assign w_gp0[i].p = A[i] ^ ~B[i];
    assign w_gp0[i].g = (A[i] & ~B[i]) | ((i == 0) & (A[i] ^ ~B[i]) & ~bin);
  end
  for (genvar l = 0; l < LOG2W; l++) begin : g_up
    gp_t [WIDTH-1:0] w_i, w_o;
    if (l == 0) begin : g_f
      assign w_i = w_gp0;
    end else begin : g_n
      assign w_i = g_up[l-1].w_o;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_b
      if (up_node(l, i)) begin : g_c
        bk_prefix_cell #(.GRAY(1'b0)) u_c (
          .i_gh(w_i[i].g), .i_ph(w_i[i].p),
          .i_gl(w_i[i-(1<<l)].g), .i_pl(w_i[i-(1<<l)].p),
          .o_g(w_o[i].g), .o_p(w_o[i].p)
        );
      end else begin : g_w
        assign w_o[i] = w_i[i];
      end
    end
  end
  assign w_up = g_up[LOG2W-1].w_o;
  for (genvar d = 0; d < LOG2W - 1; d++) begin : g_dn
    localparam int lv = LOG2W - 2 - d;
    gp_t [WIDTH-1:0] w_i, w_o;
    if (d == 0) begin : g_f
      assign w_i = r_gp1;
    end else begin : g_n
      assign w_i = g_dn[d-1].w_o;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_b
      if (down_node(lv, i)) begin : g_c
        bk_prefix_cell #(.GRAY(1'b1)) u_c (
          .i_gh(w_i[i].g), .i_ph(w_i[i].p),
          .i_gl(w_i[i-(1<<lv)].g), .i_pl(w_i[i-(1<<lv)].p),
          .o_g(w_o[i].g), .o_p(w_o[i].p)
        );
      end else begin : g_w
        assign w_o[i] = w_i[i];
      end
    end
  end
  assign w_fin = g_dn[LOG2W-2].w_o;
  for (genvar i = 0; i < WIDTH; i++) begin : g_out
    assign w_g[i]        = w_fin[i].g;
    assign w_p_unused[i] = w_fin[i].p;
  end
  assign w_diff = r_p1 ^ {w_g[WIDTH-2:0], r_c0};
  always_ff @(posedge clk) begin
    if (rst) r_v <= '0;
    else begin
      if (w_adv1) r_v.v1 <= in_valid;
      if (w_adv2) r_v.v2 <= r_v.v1;
    end
    if (w_adv1 && in_valid) begin
      r_gp1 <= w_up;
      r_p1  <= A ^ ~B;
      r_c0  <= ~bin;
    end
    if (w_adv2 && r_v.v1) begin
      r_diff <= w_diff;
      r_bout <= ~w_g[WIDTH-1];
    end
  end
  assign out_valid = r_v.v2;
  assign diff      = r_v.v2 ? r_diff : '0;
  assign bout      = r_v.v2 & r_bout;
`ifdef BK_SUB_OVERFLOW_EN
  logic r_as1, r_bs1, r_ovf;
  always_ff @(posedge clk) begin
    if (w_adv1 && in_valid) begin
      r_as1 <= A[WIDTH-1];
      r_bs1 <= B[WIDTH-1];
    end
    if (w_adv2 && r_v.v1) r_ovf <= (r_as1 != r_bs1) & (w_diff[WIDTH-1] != r_as1);
  end
  assign ovf = r_v.v2 & r_ovf;
`endif
endmodule

// File: tb/tb_sixty_four_bit_brentkung_sub_pipe.sv
// tb_sixty_four_bit_brentkung_sub_pipe: random and directed stream checked against a queue-based arithmetic model
module tb_sixty_four_bit_brentkung_sub_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, bin, bout;
  logic [63:0] A, B, diff;
`ifdef BK_SUB_OVERFLOW_EN
  logic ovf;
`endif
  typedef struct packed {
    logic [63:0] d;
    logic        b;
    logic        o;
    int          t;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int retired = 0;

  sixty_four_bit_brentkung_sub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef BK_SUB_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bi, input int t);
    exp_t e;
    logic [64:0] r;
    logic [65:0] s;
    r = {1'b0, a} - {1'b0, b} - 65'(bi);
    s = {{2{a[63]}}, a} - {{2{b[63]}}, b} - 66'(bi);
    e.d = r[63:0];
    e.b = r[64];
    e.o = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
    e.t = t;
    return e;
  endfunction

  task automatic chk(input string n, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // One cycle: drive inputs, compare outputs against the model, then advance the model across the edge
  task automatic step(input logic r, input logic iv, input logic [63:0] a, input logic [63:0] b,
                      input logic bi, input logic ordy, output logic acc);
    logic exp_ov, exp_ir;
    @(negedge clk);
    rst = r; in_valid = iv; A = a; B = b; bin = bi; out_ready = ordy;
    #1;
    exp_ov = (q.size() > 0) && (cyc >= q[0].t + 2);
    exp_ir = (q.size() < 2) || ordy;
    chk("out_valid", 66'(out_valid), 66'(exp_ov));
    chk("in_ready", 66'(in_ready), 66'(exp_ir));
    if (exp_ov) begin
      chk("diff", 66'(diff), 66'(q[0].d));
      chk("bout", 66'(bout), 66'(q[0].b));
`ifdef BK_SUB_OVERFLOW_EN
      chk("ovf", 66'(ovf), 66'(q[0].o));
`endif
    end else begin
      chk("diff_idle", 66'(diff), 66'd0);
      chk("bout_idle", 66'(bout), 66'd0);
    end
    acc = iv && in_ready && !r;
    if (r) q.delete();
    else begin
      if (out_valid && ordy) retired++;
      if (exp_ov && ordy) void'(q.pop_front());
      if (acc) q.push_back(model(a, b, bi, cyc));
    end
    cyc++;
  endtask

  initial begin
    exp_t e;
    logic acc;
    int idx, nacc;
    logic [63:0] da[5], db[5], bpa[4], bpb[4];
    logic [63:0] a, b;
    logic dbin[5];
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 66'(out_valid), 66'd0);
    chk("rst_in_ready", 66'(in_ready), 66'd1);
    chk("rst_diff", 66'(diff), 66'd0);
    chk("rst_bout", 66'(bout), 66'd0);
    e = model(64'd0, 64'd0, 1'b0, 0);
    chk("pin_zero", {1'b0, e.b, e.d}, 66'd0);
    e = model(64'd0, 64'd1, 1'b0, 0);
    chk("pin_wrap", {1'b0, e.b, e.d}, {2'b01, 64'hFFFF_FFFF_FFFF_FFFF});
    e = model(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEE, 1'b0, 0);
    chk("pin_one", {1'b0, e.b, e.d}, 66'd1);
    e = model(64'd1, 64'd1, 1'b1, 0);
    chk("pin_bin", {1'b0, e.b, e.d}, {2'b01, 64'hFFFF_FFFF_FFFF_FFFF});
    e = model(64'h8000_0000_0000_0000, 64'd1, 1'b0, 0);
    chk("pin_ovf", {e.o, e.b, e.d}, {2'b10, 64'h7FFF_FFFF_FFFF_FFFF});
    da = '{64'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 64'd1, 64'h8000_0000_0000_0000};
    db = '{64'd0, 64'd1, 64'h0123_4567_89AB_CDEE, 64'd1, 64'd1};
    dbin = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, da[i], db[i], dbin[i], 1'b1, acc);
    repeat (4) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
    bpa = '{64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    bpb = '{64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, bpa[idx & 3], bpb[idx & 3], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_accepts", 66'(idx), 66'd2);
    chk("bp_in_ready_low", 66'(in_ready), 66'd0);
    retired = 0;
    for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
      step(1'b0, idx < 4, bpa[idx & 3], bpb[idx & 3], 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", 66'(idx), 66'd4);
    chk("bp_retired", 66'(retired), 66'd4);
    step(1'b0, 1'b1, 64'd100, 64'd1, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 64'd200, 64'd2, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, acc);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("mid_rst_out_valid", 66'(out_valid), 66'd0);
    chk("mid_rst_diff", 66'(diff), 66'd0);
    chk("mid_rst_in_ready", 66'(in_ready), 66'd1);
    retired = 0;
    repeat (5) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("mid_rst_no_stale", 66'(retired), 66'd0);
    nacc = 0;
    for (int c = 0; c < 30000 && nacc < 10000; c++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = a;
        1: b = a + 64'd1;
        2: begin a = '0; b = {$urandom, $urandom}; end
        default: b = {$urandom, $urandom};
      endcase
      step(1'b0, $urandom_range(0, 3) != 0, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
      if (acc) nacc++;
    end
    chk("rand_accepts", 66'(nacc), 66'd10000);
    for (int c = 0; c < 10 && q.size() > 0; c++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("drain_empty", 66'(q.size()), 66'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
